// File: rtl/mem_logger_mc.sv
// Multi-channel capture logger: packs N_CH samples per BRAM word, optional decimation, one-shot or circular capture.
// Latency: capture write lands 1 cycle after the accepted sample; readback word appears 2 cycles after its address.
// Backpressure: none; samples arriving outside RUN (or skipped by decimation) are dropped silently.
//
// Ports:
//   clk, i_rst                 clock and synchronous active-high reset
//   i_data, i_valid            packed channel samples (ch0 in LSBs) and qualifier
//   i_run_log, i_stop_log      start/restart capture, stop capture
//   i_circular, i_decim        capture mode and decimation, both latched on RUN entry
//   i_read_log, i_addr_log_to_mem  enter readback, readback address
//   o_mem_full, o_wrapped, o_wr_ptr, o_state  registered status
//   o_data_log_from_mem, o_rd_valid           readback word (zero outside READ) and qualifier
module mem_logger_mc #(
  parameter int NB_DATA         = 8,
  parameter int N_CH            = 4,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int NB_DECIM        = 8
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [N_CH*NB_DATA-1:0]    i_data,
  input  logic                       i_valid,
  input  logic                       i_run_log,
  input  logic                       i_stop_log,
  input  logic                       i_circular,
  input  logic [NB_DECIM-1:0]        i_decim,
  input  logic                       i_read_log,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_addr_log_to_mem,
  output logic                       o_mem_full,
  output logic                       o_wrapped,
  output logic [BRAM_ADDR_WIDTH-1:0] o_wr_ptr,
  output logic [BRAM_DATA_WIDTH-1:0] o_data_log_from_mem,
  output logic                       o_rd_valid,
  output logic [1:0]                 o_state
);

  localparam int NB_IN = N_CH * NB_DATA;
  localparam int DEPTH = 2 ** BRAM_ADDR_WIDTH;
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_LAST = '1;

  generate
    if (BRAM_DATA_WIDTH < NB_IN) begin : g_width_chk
      $error("mem_logger_mc: BRAM_DATA_WIDTH must be >= N_CH*NB_DATA");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2,
    ST_READ = 2'd3
  } state_t;

  logic [BRAM_DATA_WIDTH-1:0] mem [DEPTH];

  state_t                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                       wrapped_q, wrapped_d;
  logic [NB_DECIM-1:0]        decim_cnt_q, decim_cnt_d;
  logic [NB_DECIM-1:0]        decim_q, decim_d;
  logic                       circ_q, circ_d;
  logic                       mem_full_q, mem_full_d;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                       rd_pipe_q, rd_pipe_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [BRAM_DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;

  logic                       wr_en;
  logic                       start;
  logic [BRAM_DATA_WIDTH-1:0] wr_word;
  logic [BRAM_DATA_WIDTH-1:0] rd_word;

  always_comb begin
    wr_word            = '0;
    wr_word[NB_IN-1:0] = i_data;
  end

  // Registered address feeding an unregistered array read: synchronous-read RAM.
  assign rd_word = mem[rd_addr_q];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wrapped_d   = wrapped_q;
    decim_cnt_d = decim_cnt_q;
    decim_d     = decim_q;
    circ_d      = circ_q;
    wr_en       = 1'b0;
    start       = 1'b0;

    case (state_q)
      ST_IDLE: start = i_run_log;
      ST_RUN: begin
        // i_run_log is deliberately ignored here: no restart mid-capture.
        if (i_valid) begin
          wr_en       = (decim_cnt_q == '0);
          decim_cnt_d = (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + NB_DECIM'(1);
        end
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + BRAM_ADDR_WIDTH'(1);
          if (wr_ptr_q == ADDR_LAST) begin
            if (circ_q) wrapped_d = 1'b1;
            else        state_d   = ST_FULL;
          end
        end
        // Stop does not cancel a write accepted in the same cycle.
        if (i_stop_log) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (i_run_log)       start   = 1'b1;
        else if (i_read_log) state_d = ST_READ;
      end
      ST_READ: start = i_run_log;
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d     = ST_RUN;
      wr_ptr_d    = '0;
      wrapped_d   = 1'b0;
      decim_cnt_d = '0;
      circ_d      = i_circular;
      decim_d     = i_decim;
    end

    mem_full_d = (state_d == ST_FULL) || (state_d == ST_READ);

    // Two-stage read: address register, then output register. The valid
    // pipeline only fills while READ is held, and any exit zeroes the output.
    rd_addr_d  = i_addr_log_to_mem;
    rd_pipe_d  = (state_q == ST_READ) && (state_d == ST_READ);
    rd_valid_d = rd_pipe_q && (state_d == ST_READ);
    rd_dat_d   = rd_valid_d ? rd_word : '0;
  end

  // Memory contents survive reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (wr_en && !i_rst) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      decim_cnt_q <= '0;
      decim_q     <= '0;
      circ_q      <= 1'b0;
      mem_full_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_pipe_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      decim_cnt_q <= decim_cnt_d;
      decim_q     <= decim_d;
      circ_q      <= circ_d;
      mem_full_q  <= mem_full_d;
      rd_addr_q   <= rd_addr_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_dat_q    <= rd_dat_d;
    end
  end

  assign o_state             = state_q;
  assign o_mem_full          = mem_full_q;
  assign o_wrapped           = wrapped_q;
  assign o_wr_ptr            = wr_ptr_q;
  assign o_data_log_from_mem = rd_dat_q;
  assign o_rd_valid          = rd_valid_q;

endmodule

// File: tb/tb_mem_logger_mc.sv
// Bench for mem_logger_mc: 16-deep 4x8-bit instance plus a 4-deep 3x8-bit instance for zero padding.
// Latency: readback expectations are queued at address issue and popped when o_rd_valid is seen.
// Backpressure: none; stimulus is fixed-length directed sequences.
module tb_mem_logger_mc;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic        valid, run, stop, circ, rd;
  logic [7:0]  decim;
  logic [3:0]  addr;
  logic        o_full, o_wrapped, o_rd_valid;
  logic [3:0]  o_wr_ptr;
  logic [31:0] o_data;
  logic [1:0]  o_state;

  logic [23:0] d24;
  logic        v24, run24, rd24;
  logic [1:0]  addr24;
  logic        o_full24, o_wrapped24, o_rd_valid24;
  logic [1:0]  o_wr_ptr24;
  logic [31:0] o_data24;
  logic [1:0]  o_state24;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  expa_q[$];
  logic [31:0] exp24_q[$];
  logic [3:0]  rd_a[16];
  logic [31:0] rd_e[16];

  mem_logger_mc #(.NB_DATA(8), .N_CH(4), .BRAM_ADDR_WIDTH(4), .BRAM_DATA_WIDTH(32), .NB_DECIM(8)) u_dut (
    .clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .i_run_log(run),
    .i_stop_log(stop), .i_circular(circ), .i_decim(decim), .i_read_log(rd),
    .i_addr_log_to_mem(addr), .o_mem_full(o_full), .o_wrapped(o_wrapped),
    .o_wr_ptr(o_wr_ptr), .o_data_log_from_mem(o_data), .o_rd_valid(o_rd_valid),
    .o_state(o_state)
  );

  mem_logger_mc #(.NB_DATA(8), .N_CH(3), .BRAM_ADDR_WIDTH(2), .BRAM_DATA_WIDTH(32), .NB_DECIM(8)) u_dut24 (
    .clk(clk), .i_rst(rst), .i_data(d24), .i_valid(v24), .i_run_log(run24),
    .i_stop_log(1'b0), .i_circular(1'b0), .i_decim(8'd0), .i_read_log(rd24),
    .i_addr_log_to_mem(addr24), .o_mem_full(o_full24), .o_wrapped(o_wrapped24),
    .o_wr_ptr(o_wr_ptr24), .o_data_log_from_mem(o_data24), .o_rd_valid(o_rd_valid24),
    .o_state(o_state24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every word the DUTs present as valid against the queue.
  always @(negedge clk) begin
    if (o_rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h", o_data);
      end else begin
        logic [31:0] e;
        logic [3:0]  a;
        e = exp_q.pop_front();
        a = expa_q.pop_front();
        if (o_data !== e) begin
          bad++;
          $display("FAIL rd_data addr=%0d got=%h exp=%h", a, o_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o_rd_valid24) begin
      total++;
      if (exp24_q.size() == 0) begin
        bad++;
        $display("FAIL rd24_unexpected got=%h", o_data24);
      end else begin
        logic [31:0] e;
        e = exp24_q.pop_front();
        if (o_data24 !== e) begin
          bad++;
          $display("FAIL rd24_data got=%h exp=%h", o_data24, e);
        end
      end
    end
  end

  // Enter READ from FULL, issue n addresses back to back, and return in the
  // cycle where the last queued word is on the output (still in READ).
  task automatic do_read(input int n);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("read_state", 32'(o_state), 32'd3);
    chk("read_full", 32'(o_full), 32'd1);
    for (int i = 0; i < n; i++) begin
      addr = rd_a[i];
      exp_q.push_back(rd_e[i]);
      expa_q.push_back(rd_a[i]);
      tick();
    end
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(o_state), 32'd0);
    chk({tag, "_full"}, 32'(o_full), 32'd0);
    chk({tag, "_wrapped"}, 32'(o_wrapped), 32'd0);
    chk({tag, "_wr_ptr"}, 32'(o_wr_ptr), 32'd0);
    chk({tag, "_rd_valid"}, 32'(o_rd_valid), 32'd0);
    chk({tag, "_data"}, o_data, 32'd0);
  endtask

  initial begin
    logic [23:0] v24s[4];
    rst = 1'b1; data = '0; valid = 0; run = 0; stop = 0; circ = 0; rd = 0;
    decim = '0; addr = '0;
    d24 = '0; v24 = 0; run24 = 0; rd24 = 0; addr24 = '0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;

    // One-shot, no decimation, full depth.
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("os_run_state", 32'(o_state), 32'd1);
    for (int k = 0; k < 16; k++) begin
      valid = 1'b1;
      data  = 32'(k) * 32'h01010101;
      tick();
      if (k == 7) chk("os_mid_wr_ptr", 32'(o_wr_ptr), 32'd8);
    end
    valid = 1'b0;
    chk("os_full_state", 32'(o_state), 32'd2);
    chk("os_full_flag", 32'(o_full), 32'd1);
    chk("os_wr_ptr", 32'(o_wr_ptr), 32'd0);
    chk("os_wrapped", 32'(o_wrapped), 32'd0);
    for (int k = 0; k < 16; k++) begin
      rd_a[k] = 4'((k * 5) % 16);
      rd_e[k] = 32'((k * 5) % 16) * 32'h01010101;
    end
    do_read(16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_read");

    // Decimation by 3: samples 0,3,...,45 stored.
    decim = 8'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int s = 0; s < 48; s++) begin
      valid = 1'b1;
      data  = 32'(s);
      tick();
      if (s == 44) begin
        chk("dec_s44_state", 32'(o_state), 32'd1);
        chk("dec_s44_wr_ptr", 32'(o_wr_ptr), 32'd15);
      end
      if (s == 45) chk("dec_s45_state", 32'(o_state), 32'd2);
    end
    valid = 1'b0;
    chk("dec_wr_ptr", 32'(o_wr_ptr), 32'd0);
    rd_a[0] = 4'd0;  rd_e[0] = 32'd0;
    rd_a[1] = 4'd1;  rd_e[1] = 32'd3;
    rd_a[2] = 4'd15; rd_e[2] = 32'd45;
    rd_a[3] = 4'd7;  rd_e[3] = 32'd21;
    rd_a[4] = 4'd14; rd_e[4] = 32'd42;
    do_read(5);
    run = 1'b1;
    rd  = 1'b1;
    tick();
    run = 1'b0;
    rd  = 1'b0;
    chk("rdexit_state", 32'(o_state), 32'd1);
    chk("rdexit_full", 32'(o_full), 32'd0);
    chk("rdexit_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rdexit_data", o_data, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_empty_state", 32'(o_state), 32'd2);

    // Run and read together in FULL: run wins.
    circ  = 1'b1;
    decim = 8'd0;
    run   = 1'b1;
    rd    = 1'b1;
    tick();
    run = 1'b0;
    rd  = 1'b0;
    chk("prio_state", 32'(o_state), 32'd1);

    // Circular: 20 writes then stop.
    for (int v = 0; v < 20; v++) begin
      valid = 1'b1;
      data  = 32'(v);
      tick();
      if (v == 14) chk("circ_v14_wrapped", 32'(o_wrapped), 32'd0);
      if (v == 15) begin
        chk("circ_v15_wrapped", 32'(o_wrapped), 32'd1);
        chk("circ_v15_state", 32'(o_state), 32'd1);
        chk("circ_v15_wr_ptr", 32'(o_wr_ptr), 32'd0);
      end
    end
    valid = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    chk("circ_state", 32'(o_state), 32'd2);
    chk("circ_wrapped", 32'(o_wrapped), 32'd1);
    chk("circ_wr_ptr", 32'(o_wr_ptr), 32'd4);
    rd_a[0] = 4'd4;  rd_e[0] = 32'd4;
    rd_a[1] = 4'd3;  rd_e[1] = 32'd19;
    rd_a[2] = 4'd0;  rd_e[2] = 32'd16;
    rd_a[3] = 4'd15; rd_e[3] = 32'd15;
    do_read(4);

    // Gapped circular capture: run mid-RUN ignored, stop lands with the write at 15.
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("gap_entry_wr_ptr", 32'(o_wr_ptr), 32'd0);
    chk("gap_entry_wrapped", 32'(o_wrapped), 32'd0);
    for (int c = 0; c <= 30; c++) begin
      valid = (c % 2 == 0);
      data  = 32'h000000A0 + 32'(c / 2);
      run   = (c == 10);
      stop  = (c == 30);
      tick();
      if (c == 11) chk("gap_run_ignored_wr_ptr", 32'(o_wr_ptr), 32'd6);
    end
    valid = 1'b0;
    run   = 1'b0;
    stop  = 1'b0;
    chk("gap_state", 32'(o_state), 32'd2);
    chk("gap_wrapped", 32'(o_wrapped), 32'd1);
    chk("gap_wr_ptr", 32'(o_wr_ptr), 32'd0);
    rd_a[0] = 4'd15; rd_e[0] = 32'hAF;
    rd_a[1] = 4'd5;  rd_e[1] = 32'hA5;
    rd_a[2] = 4'd6;  rd_e[2] = 32'hA6;
    rd_a[3] = 4'd0;  rd_e[3] = 32'hA0;
    do_read(4);

    // Reset mid-RUN at wr_ptr 7, then a short one-shot run from address 0.
    circ = 1'b0;
    run  = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      valid = 1'b1;
      data  = 32'h000000B0 + 32'(i);
      tick();
    end
    valid = 1'b0;
    chk("pre_rst_wr_ptr", 32'(o_wr_ptr), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_run");
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      data  = 32'h000000C0 + 32'(i);
      tick();
    end
    valid = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    chk("early_state", 32'(o_state), 32'd2);
    chk("early_wr_ptr", 32'(o_wr_ptr), 32'd3);
    rd_a[0] = 4'd0; rd_e[0] = 32'hC0;
    rd_a[1] = 4'd2; rd_e[1] = 32'hC2;
    rd_a[2] = 4'd3; rd_e[2] = 32'hB3;
    rd_a[3] = 4'd7; rd_e[3] = 32'hA7;
    do_read(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 24-bit payload in a 32-bit word: upper byte must read back as zero.
    v24s[0] = 24'hFFFFFF;
    v24s[1] = 24'h123456;
    v24s[2] = 24'hABCDEF;
    v24s[3] = 24'h800001;
    run24 = 1'b1;
    tick();
    run24 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v24 = 1'b1;
      d24 = v24s[i];
      tick();
    end
    v24 = 1'b0;
    chk("w24_state", 32'(o_state24), 32'd2);
    chk("w24_wr_ptr", 32'(o_wr_ptr24), 32'd0);
    rd24 = 1'b1;
    tick();
    rd24 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr24 = 2'(3 - i);
      exp24_q.push_back({8'h00, v24s[3 - i]});
      tick();
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("w24_rst_data", o_data24, 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("scoreboard24_drained", 32'(exp24_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_logger_mc.md
Name: mem_logger_mc

Overview:
Parametrised multi-channel successor to the single-channel capture logger. It packs N_CH samples per capture into one BRAM word and supports optional decimation. Capture runs in one-shot mode (stop at full) or circular mode (overwrite until stopped). Software reads the log back by address with a fixed latency. It sits between the filter output bus and the host register/readback interface.

Parameters:
NB_DATA, 8, bits per channel sample
N_CH, 4, number of channels captured per write
BRAM_ADDR_WIDTH, 15, log2 of log depth in words (DEPTH = 2**BRAM_ADDR_WIDTH)
BRAM_DATA_WIDTH, 32, BRAM word width; must be >= N_CH*NB_DATA (elaboration error otherwise)
NB_DECIM, 8, width of decimation control

Ports:
clk  in  1  system clock, all logic rising-edge
i_rst  in  1  synchronous active-high reset
i_data  in  N_CH*NB_DATA  channel samples, ch0 in LSBs
i_valid  in  1  i_data qualifier
i_run_log  in  1  start/restart capture (level, sampled each cycle)
i_stop_log  in  1  stop capture (circular mode)
i_circular  in  1  0 = one-shot, 1 = circular; latched on RUN entry
i_decim  in  NB_DECIM  write every (i_decim+1)th valid sample; latched on RUN entry
i_read_log  in  1  enter readback
i_addr_log_to_mem  in  BRAM_ADDR_WIDTH  readback address
o_mem_full  out  1  capture complete (FULL or READ)
o_wrapped  out  1  circular capture overwrote at least once
o_wr_ptr  out  BRAM_ADDR_WIDTH  next write address (oldest word when o_wrapped=1)
o_data_log_from_mem  out  BRAM_DATA_WIDTH  readback word, zero-padded MSBs
o_rd_valid  out  1  o_data_log_from_mem valid
o_state  out  2  IDLE=0, RUN=1, FULL=2, READ=3

Behaviour:
- Reset: state IDLE; all outputs 0; wr_ptr, decim counter and wrapped cleared. Memory contents are not cleared. Reset wins over every other input, including mid-RUN and mid-READ.
- Memory: inferred single-clock simple dual-port RAM, DEPTH x BRAM_DATA_WIDTH. Write data = {zero pad, i_data}.
- IDLE -> RUN on i_run_log. On entry: wr_ptr=0, wrapped=0, decim_cnt=0; latch i_circular and i_decim.
- RUN write rule: write occurs in a cycle with i_valid=1 and decim_cnt==0. decim_cnt increments on each valid and wraps to 0 after reaching the latched decim value. decim=0 writes every valid sample.
- On write: mem[wr_ptr] <= data; wr_ptr increments modulo DEPTH.
- One-shot: the write at wr_ptr==DEPTH-1 moves state to FULL on the next cycle. Exactly DEPTH words are written; wr_ptr reads 0 in FULL.
- Circular: the write at DEPTH-1 sets o_wrapped and wraps wr_ptr to 0; state stays RUN. i_stop_log moves RUN -> FULL, and a write in that same cycle still occurs.
- i_stop_log in one-shot mode behaves identically (early stop, partial log; o_wr_ptr = words written).
- i_run_log while in RUN is ignored; no restart.
- FULL: o_mem_full=1. i_run_log -> RUN (restart, priority); else i_read_log -> READ.
- READ: o_mem_full=1. Address registered each cycle; o_data_log_from_mem = mem[addr] exactly 2 cycles after the address is presented. o_rd_valid rises 2 cycles after READ entry and stays high while in READ. i_run_log -> RUN (clears o_mem_full, o_rd_valid and o_data to 0 on the transition cycle). Otherwise the block stays in READ.
- Outside READ: o_data_log_from_mem=0, o_rd_valid=0.
- o_state, o_mem_full, o_wrapped and o_wr_ptr are registered. They reflect the current state, with no combinational path from inputs.

Test Plan:
- BRAM_ADDR_WIDTH=4, N_CH=4, NB_DATA=8, one-shot, decim=0: i_valid every cycle, data = word index*0x01010101 -> FULL after 16 writes. o_wr_ptr=0, o_wrapped=0. Readback addr k returns k*0x01010101 two cycles after presentation, and o_rd_valid is 1.
- Decimation: decim=2, 48 valid samples counting 0..47 -> 16 words stored = samples 0,3,6,...,45; FULL after sample 45.
- Circular: depth 16, 20 writes of values 0..19, then i_stop_log -> FULL with o_wrapped=1 and o_wr_ptr=4. Readback addr 4 = 4, addr 3 = 19.
- Gaps/boundary: i_valid toggling 1/0 and i_stop_log coinciding with a valid write at addr 15 -> that write lands and the block goes to FULL. i_run_log asserted mid-RUN -> no pointer reset.
- Reset mid-RUN at wr_ptr=7 and mid-READ -> next cycle o_state=0 and all outputs 0. A new run overwrites from addr 0.
- Priority: i_run_log and i_read_log high together in FULL -> RUN. N_CH*NB_DATA=24 -> readback MSBs [31:24]=0.
